// File: rtl/avmm_reg_slave.sv
// avmm_reg_slave: Avalon-MM register bank with programmable wait states and
// a fixed-latency pipelined read path.
// Optional macro AVS_REG_IRQ_EN adds an IRQ status/mask register pair
// (top two registers) plus irq_set / irq ports.
`timescale 1ns/1ps

module avmm_reg_slave #(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned RD_LAT      = 2,
    parameter logic [31:0] RST_VAL     = 32'h0,
    parameter logic [31:0] BAD_DATA    = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              address,
    input  logic                     read,
    input  logic                     write,
    input  logic [3:0]               byteenable,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic                     readdatavalid,
    output logic                     waitrequest,
`ifdef AVS_REG_IRQ_EN
    input  logic [31:0]              irq_set,
    output logic                     irq,
`endif
    output logic [NUM_REGS*32-1:0]   regs_q
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WCNT_W = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCEPT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wcnt_nxt;
    logic                wait_nxt;
    logic                cmd;
    logic                accept;
    logic                wr_hit;
    logic                rd_acc;
    logic [31:0]         off_w;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [31:0]         be_mask;
    logic [31:0]         rd_val;
    logic [31:0]         bank     [NUM_REGS];
    logic [31:0]         bank_nxt [NUM_REGS];
    logic [RD_LAT-1:0]   pipe_v;
    logic [31:0]         pipe_d   [RD_LAT];
`ifdef AVS_REG_IRQ_EN
    logic [31:0]         status_clr;
`endif

    // Command handshake: a command is taken on any edge where waitrequest is low.
    assign cmd    = read | write;
    assign accept = cmd & ~waitrequest;
    assign wr_hit = accept & write & in_range;
    assign rd_acc = accept & read & ~write;

    // Address decode; BASE_ADDR is aligned so the low two bits never borrow.
    assign off_w    = (address - BASE_ADDR) >> 2;
    assign in_range = off_w < 32'(NUM_REGS);
    assign idx      = off_w[IDX_W-1:0];
    assign be_mask  = {{8{byteenable[3]}}, {8{byteenable[2]}},
                       {8{byteenable[1]}}, {8{byteenable[0]}}};
    assign rd_val   = in_range ? bank[idx] : BAD_DATA;

    // FSM state register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // FSM next state: the IDLE cycle counts as the first wait state.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE: begin
                if (cmd && (WAIT_STATES != 0)) begin
                    wcnt_nxt  = WCNT_W'(WAIT_STATES - 1);
                    state_nxt = (WAIT_STATES == 1) ? ST_ACCEPT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cmd) begin
                    state_nxt = ST_IDLE;
                end else begin
                    wcnt_nxt = wcnt - WCNT_W'(1);
                    if (wcnt == WCNT_W'(1)) begin
                        state_nxt = ST_ACCEPT;
                    end
                end
            end
            ST_ACCEPT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM output: waitrequest level for the coming cycle.
    always_comb begin
        wait_nxt = 1'b1;
        case (state_nxt)
            ST_IDLE:   wait_nxt = (WAIT_STATES != 0);
            ST_ACCEPT: wait_nxt = 1'b0;
            default:   wait_nxt = 1'b1;
        endcase
    end

    // Registered waitrequest, held high through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitrequest <= 1'b1;
        end else begin
            waitrequest <= wait_nxt;
        end
    end

    // Next register bank contents from byte-enabled writes (and IRQ status).
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            bank_nxt[i] = bank[i];
            if (wr_hit && (idx == IDX_W'(i))) begin
                bank_nxt[i] = (bank[i] & ~be_mask) | (writedata & be_mask);
            end
        end
`ifdef AVS_REG_IRQ_EN
        status_clr = '0;
        if (wr_hit && (idx == IDX_W'(NUM_REGS - 1))) begin
            status_clr = writedata & be_mask;
        end
        bank_nxt[NUM_REGS-1] = (bank[NUM_REGS-1] & ~status_clr) | irq_set;
`endif
    end

    // Register bank storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= bank_nxt[i];
            end
        end
    end

`ifdef AVS_REG_IRQ_EN
    // Interrupt line follows the post-edge status and mask values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(bank_nxt[NUM_REGS-1] & bank_nxt[NUM_REGS-2]);
        end
    end
`endif

    // Flat view of the bank.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[32*g +: 32] = bank[g];
    end

    // Read pipeline: accepted read data emerges RD_LAT edges after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v        <= '0;
            readdatavalid <= 1'b0;
            readdata      <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_d[k] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_acc;
            pipe_d[0] <= rd_val;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
            readdatavalid <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                readdata <= pipe_d[RD_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_avmm_reg_slave.sv
// Bench for avmm_reg_slave: two instances (wait-state/latency-2 bank at
// 0x1000 and a zero-wait/latency-3 bank at 0) share one command bus,
// steered by sel. A read scoreboard checks data, order and exact latency.
`timescale 1ns/1ps

module tb_avmm_reg_slave;

    localparam int unsigned A_WS  = 2;
    localparam int unsigned A_LAT = 2;
    localparam int unsigned B_WS  = 0;
    localparam int unsigned B_LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_be;
    logic         bus_read;
    logic         bus_write;
    logic         a_read, a_write, b_read, b_write;
    logic [31:0]  a_rdata, b_rdata;
    logic         a_rvalid, b_rvalid, a_wr, b_wr;
    logic [255:0] a_regs, b_regs;
    logic [255:0] snap;
`ifdef AVS_REG_IRQ_EN
    logic [31:0]  a_irq_set, b_irq_set;
    logic         a_irq, b_irq;
    bit           irq_at_acc;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] a_qd[$];
    int          a_qt[$];
    logic [31:0] b_qd[$];
    int          b_qt[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a_read  = bus_read  & ~sel;
    assign a_write = bus_write & ~sel;
    assign b_read  = bus_read  &  sel;
    assign b_write = bus_write &  sel;

    avmm_reg_slave #(
        .NUM_REGS(8), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(A_WS),
        .RD_LAT(A_LAT), .RST_VAL(32'h0), .BAD_DATA(32'hDEAD_BEEF)
    ) u_dut_a (
        .clk(clk), .rst(rst), .address(bus_addr), .read(a_read),
        .write(a_write), .byteenable(bus_be), .writedata(bus_wdata),
        .readdata(a_rdata), .readdatavalid(a_rvalid), .waitrequest(a_wr),
`ifdef AVS_REG_IRQ_EN
        .irq_set(a_irq_set), .irq(a_irq),
`endif
        .regs_q(a_regs)
    );

    avmm_reg_slave #(
        .NUM_REGS(8), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(B_WS),
        .RD_LAT(B_LAT), .RST_VAL(32'h0), .BAD_DATA(32'hDEAD_BEEF)
    ) u_dut_b (
        .clk(clk), .rst(rst), .address(bus_addr), .read(b_read),
        .write(b_write), .byteenable(bus_be), .writedata(bus_wdata),
        .readdata(b_rdata), .readdatavalid(b_rvalid), .waitrequest(b_wr),
`ifdef AVS_REG_IRQ_EN
        .irq_set(b_irq_set), .irq(b_irq),
`endif
        .regs_q(b_regs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read scoreboard: every readdatavalid must match the oldest pending read.
    always @(negedge clk) begin
        if (a_rvalid) begin
            if (a_qd.size() == 0) begin
                check("a_spurious_rvalid", 32'(a_rvalid), 32'd0);
            end else begin
                check("a_rdata", a_rdata, a_qd.pop_front());
                check("a_rlat_cycle", 32'(cyc), 32'(a_qt.pop_front()));
            end
        end else if (a_qt.size() > 0 && a_qt[0] < cyc) begin
            check("a_missing_rvalid", 32'(a_rvalid), 32'd1);
            void'(a_qd.pop_front());
            void'(a_qt.pop_front());
        end
        if (b_rvalid) begin
            if (b_qd.size() == 0) begin
                check("b_spurious_rvalid", 32'(b_rvalid), 32'd0);
            end else begin
                check("b_rdata", b_rdata, b_qd.pop_front());
                check("b_rlat_cycle", 32'(cyc), 32'(b_qt.pop_front()));
            end
        end else if (b_qt.size() > 0 && b_qt[0] < cyc) begin
            check("b_missing_rvalid", 32'(b_rvalid), 32'd1);
            void'(b_qd.pop_front());
            void'(b_qt.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one command, hold it through waitrequest, check wait count,
    // and queue the expected read response.
    task automatic do_cmd(input bit s, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input logic [31:0] exp,
                          input int exp_waits);
        int    waits;
        logic  wreq;
        string tag;
        tag       = s ? "b" : "a";
        waits     = 0;
        sel       = s;
        bus_addr  = addr;
        bus_be    = be;
        bus_wdata = data;
        bus_read  = rd;
        bus_write = wr;
        wreq      = s ? b_wr : a_wr;
        while (wreq === 1'b1 && waits < 16) begin
            waits++;
            @(negedge clk);
            wreq = s ? b_wr : a_wr;
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
`ifdef AVS_REG_IRQ_EN
        if (irq_at_acc) a_irq_set = 32'h1;
`endif
        @(negedge clk);
`ifdef AVS_REG_IRQ_EN
        a_irq_set  = 32'h0;
        irq_at_acc = 1'b0;
`endif
        if (rd && !wr) begin
            if (s) begin
                b_qd.push_back(exp);
                b_qt.push_back(cyc + B_LAT);
            end else begin
                a_qd.push_back(exp);
                a_qt.push_back(cyc + A_LAT);
            end
        end
        bus_read  = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((a_qd.size() + b_qd.size()) > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 32'(a_qd.size() + b_qd.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = '0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
`ifdef AVS_REG_IRQ_EN
        a_irq_set  = '0;
        b_irq_set  = '0;
        irq_at_acc = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("a_wr_in_rst", 32'(a_wr), 32'd1);
        check("b_wr_in_rst", 32'(b_wr), 32'd1);
        check("a_rdata_rst", a_rdata, 32'h0);
        rst = 1'b0;
        idle(3);

        // Reset values, wait-state count and read latency on every register.
        for (int i = 0; i < 8; i++) begin
            do_cmd(0, 1, 0, 32'h1000 + 32'(i * 4), 4'h0, 32'h0, 32'h0, A_WS);
        end
        drain();

        // Byte-enabled writes; regs_q must show the value right after the edge.
        do_cmd(0, 0, 1, 32'h100C, 4'b0101, 32'h1234_5678, 32'h0, A_WS);
        check("a_reg3_after_wr", a_regs[127:96], 32'h0034_0078);
        do_cmd(0, 1, 0, 32'h100F, 4'h0, 32'h0, 32'h0034_0078, A_WS);
        do_cmd(0, 0, 1, 32'h100C, 4'b0000, 32'hFFFF_FFFF, 32'h0, A_WS);
        check("a_reg3_be0_noop", a_regs[127:96], 32'h0034_0078);
        do_cmd(0, 0, 1, 32'h100C, 4'b1010, 32'hAABB_CCDD, 32'h0, A_WS);
        do_cmd(0, 1, 0, 32'h100C, 4'h0, 32'h0, 32'hAA34_CC78, A_WS);

        // Out-of-range reads above and below the bank; dropped write.
        snap = a_regs;
        do_cmd(0, 1, 0, 32'h1020, 4'h0, 32'h0, 32'hDEAD_BEEF, A_WS);
        do_cmd(0, 1, 0, 32'h0FFC, 4'h0, 32'h0, 32'hDEAD_BEEF, A_WS);
        do_cmd(0, 0, 1, 32'h1020, 4'hF, 32'hFFFF_FFFF, 32'h0, A_WS);
        idle(1);
        check("a_oor_wr_nochange", 32'(a_regs == snap), 32'd1);

        // Read and write together: write lands, no read response.
        do_cmd(0, 1, 1, 32'h1014, 4'hF, 32'h1111_1111, 32'h0, A_WS);
        idle(A_LAT + 2);
        check("a_rw_both_reg5", a_regs[191:160], 32'h1111_1111);
        do_cmd(0, 1, 0, 32'h1014, 4'h0, 32'h0, 32'h1111_1111, A_WS);

        // Command withdrawn during WAIT: no write, FSM back to IDLE.
        sel       = 1'b0;
        bus_addr  = 32'h1018;
        bus_be    = 4'hF;
        bus_wdata = 32'hFFFF_FFFF;
        bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
        idle(4);
        check("a_dropped_wr_reg6", a_regs[223:192], 32'h0);
        do_cmd(0, 1, 0, 32'h1018, 4'h0, 32'h0, 32'h0, A_WS);
        drain();

        // Zero-wait bank: preload, then back-to-back reads on consecutive edges.
        do_cmd(1, 0, 1, 32'h4,  4'hF, 32'hA, 32'h0, B_WS);
        do_cmd(1, 0, 1, 32'h8,  4'hF, 32'hB, 32'h0, B_WS);
        do_cmd(1, 0, 1, 32'h10, 4'hF, 32'hC, 32'h0, B_WS);
        do_cmd(1, 1, 0, 32'h4,  4'h0, 32'h0, 32'hA, B_WS);
        do_cmd(1, 1, 0, 32'h8,  4'h0, 32'h0, 32'hB, B_WS);
        do_cmd(1, 1, 0, 32'h10, 4'h0, 32'h0, 32'hC, B_WS);
        drain();
        check("b_rdata_hold", b_rdata, 32'hC);

        // Reset with two reads in flight: nothing may emerge afterwards.
        do_cmd(1, 1, 0, 32'h4, 4'h0, 32'h0, 32'hA, B_WS);
        do_cmd(1, 1, 0, 32'h8, 4'h0, 32'h0, 32'hB, B_WS);
        rst = 1'b1;
        a_qd.delete(); a_qt.delete(); b_qd.delete(); b_qt.delete();
        @(negedge clk);
        check("b_wr_mid_rst", 32'(b_wr), 32'd1);
        check("a_wr_mid_rst", 32'(a_wr), 32'd1);
        check("b_rdata_mid_rst", b_rdata, 32'h0);
        check("b_reg1_rst", b_regs[63:32], 32'h0);
        check("a_reg3_rst", a_regs[127:96], 32'h0);
        rst = 1'b0;
        idle(8);
        check("b_rvalid_post_rst", 32'(b_rvalid), 32'd0);
        do_cmd(1, 1, 0, 32'h10, 4'h0, 32'h0, 32'h0, B_WS);
        drain();

`ifdef AVS_REG_IRQ_EN
        // IRQ: set, set-wins-over-clear, then clean clear.
        do_cmd(0, 0, 1, 32'h1018, 4'hF, 32'h1, 32'h0, A_WS);
        check("irq_idle", 32'(a_irq), 32'd0);
        a_irq_set = 32'h1;
        @(negedge clk);
        a_irq_set = 32'h0;
        check("irq_after_set", 32'(a_irq), 32'd1);
        check("irq_status_set", a_regs[255:224], 32'h1);
        irq_at_acc = 1'b1;
        do_cmd(0, 0, 1, 32'h101C, 4'hF, 32'h1, 32'h0, A_WS);
        check("irq_set_wins", a_regs[255:224], 32'h1);
        check("irq_still_high", 32'(a_irq), 32'd1);
        do_cmd(0, 0, 1, 32'h101C, 4'hF, 32'h1, 32'h0, A_WS);
        check("irq_status_clr", a_regs[255:224], 32'h0);
        check("irq_cleared", 32'(a_irq), 32'd0);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avmm_reg_slave.md
Name: avmm_reg_slave

Overview:
- Avalon-MM slave register bank: the downstream target of the I2C-to-Avalon bridge master.
- Decodes the bridge's 32-bit byte address and applies byte-enabled writes to a bank of 32-bit control registers.
- Returns pipelined read data with readdatavalid.
- Inserts a configurable number of wait states through waitrequest; the bridge sees a real handshake.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (2..64).
- BASE_ADDR, 32'h0000_0000, byte base address of the bank; must be aligned to NUM_REGS*4.
- WAIT_STATES, 1, cycles waitrequest stays high on each new command before acceptance (0..3).
- RD_LAT, 2, cycles from read acceptance edge to readdatavalid (1..4).
- RST_VAL, 32'h0, reset value of every register.
- BAD_DATA, 32'hDEAD_BEEF, readdata returned for out-of-range addresses.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  32  byte address from the bridge.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  4  per-byte write enable; bit n covers writedata[8n+7:8n].
- writedata  in  32  write data.
- readdata  out  32  read data, valid only with readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  command not accepted this cycle.
- regs_q  out  NUM_REGS*32  flat register contents; reg i is [32i+31:32i].

Behaviour:
- Reset (async assert, sync release): all registers = RST_VAL, readdata = 0, readdatavalid = 0, read pipeline flushed, FSM = IDLE, waitrequest = 1 while rst is high.
- Decode: in range when address[31:2] - BASE_ADDR[31:2] < NUM_REGS; index = that difference. address[1:0] is ignored.
- FSM IDLE:
  - No command: waitrequest = 0 if WAIT_STATES = 0, else 1.
  - read or write with WAIT_STATES = 0: accept in the same cycle.
  - read or write with WAIT_STATES > 0: go to WAIT and load wcnt = WAIT_STATES-1.
- FSM WAIT: waitrequest = 1; decrement wcnt; at 0 go to ACCEPT.
- FSM ACCEPT: waitrequest = 0; the command is accepted at this edge; return to IDLE.
- Command dropped (read and write both low) during WAIT: return to IDLE, no side effects.
- Accepted write: each byte with byteenable=1 is written at the acceptance edge. Out-of-range writes are dropped silently. byteenable = 0 is a legal no-op.
- Accepted read: the register value at the acceptance edge (pre-write value is not applicable, since there is one command per cycle) enters an RD_LAT-deep shift pipeline. readdatavalid pulses exactly RD_LAT cycles later with that data. Out-of-range reads return BAD_DATA.
- Pipeline: up to RD_LAT reads in flight; no backpressure. readdatavalid is never asserted without a matching accepted read.
- read and write both high: protocol error; write takes priority; the read is ignored and produces no readdatavalid.
- Read after write to the same register, accepted on a later edge: returns the new value.
- Reset mid-operation: in-flight reads are discarded and no late readdatavalid is produced. A pending WAIT is cancelled.
- readdata holds its last value when readdatavalid = 0, except after reset, when it is 0.
- regs_q is registered directly from the bank; the new value is visible the cycle after the write edge.

Optional Feature:
- Macro: AVS_REG_IRQ_EN.
- When defined:
  - Extra ports: irq_set (in, 32) and irq (out, 1).
  - Reg NUM_REGS-1 = IRQ status. Each bit sets on an irq_set pulse. A write of 1 to a byte-enabled bit clears it. Set wins over a simultaneous clear.
  - Reg NUM_REGS-2 = IRQ mask, plain R/W.
  - irq = |(status & mask), registered, reset 0.
- When undefined: the ports do not exist and all registers are plain R/W.

Test Plan:
- Reset then read idx 0..NUM_REGS-1 -> every readdata = 32'h0; readdatavalid arrives RD_LAT cycles after acceptance; waitrequest high exactly WAIT_STATES cycles per command.
- Write 32'h1234_5678 to idx 3 with byteenable=4'b0101, then read idx 3 -> 32'h0034_0078; regs_q[127:96] updated the cycle after the write edge.
- Back-to-back reads with WAIT_STATES=0, RD_LAT=3, idx 1,2,4 preloaded 32'hA, B, C -> three consecutive readdatavalid pulses in order A, B, C, starting 3 cycles after the first acceptance.
- Read at BASE_ADDR+NUM_REGS*4 -> BAD_DATA; write there -> no regs_q change.
- Assert rst with 2 reads in flight -> no readdatavalid after reset, registers = RST_VAL, waitrequest = 1 during reset.
- (AVS_REG_IRQ_EN) mask=32'h1, pulse irq_set[0] -> irq = 1 next cycle; write 32'h1 to status while irq_set[0] is pulsed again -> bit stays set; a clean write of 1 -> irq = 0.
